// File: rtl/branch_ctrl_pkg.sv
// ============================================================================
// Module  : branch_ctrl_pkg
// Brief   : Shared opcodes, funct3 encodings and redirect FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package branch_ctrl_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } redir_state_e;

endpackage

`default_nettype wire

// File: rtl/branch_redirect_ctrl_if.sv
// ============================================================================
// Module  : branch_redirect_ctrl_if
// Brief   : EX-side decode inputs and fetch-side redirect handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface branch_redirect_ctrl_if #(
  parameter int AWIDTH = 32
);
  logic              ex_valid_i;
  logic [6:0]        opcode_i;
  logic [2:0]        funct3_i;
  logic              breq_i;
  logic              brlt_i;
  logic [AWIDTH-1:0] target_i;
  logic              redirect_ready_i;
  logic              busy_o;
  logic              flush_o;
  logic              redirect_valid_o;
  logic [AWIDTH-1:0] redirect_pc_o;
  logic              misalign_o;

  modport master (
    output ex_valid_i, opcode_i, funct3_i, breq_i, brlt_i, target_i, redirect_ready_i,
    input  busy_o, flush_o, redirect_valid_o, redirect_pc_o, misalign_o
  );

  modport slave (
    input  ex_valid_i, opcode_i, funct3_i, breq_i, brlt_i, target_i, redirect_ready_i,
    output busy_o, flush_o, redirect_valid_o, redirect_pc_o, misalign_o
  );
endinterface

`default_nettype wire

// File: rtl/branch_taken_dec.sv
// ============================================================================
// Module  : branch_taken_dec
// Brief   : Combinational taken/not-taken decode from opcode, funct3 and flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_taken_dec
  import branch_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       breq_i,
  input  logic       brlt_i,
  output logic       taken,
  output logic       is_branch
);

  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b0;
    case (opcode_i)
      OP_BRANCH: begin
        is_branch = 1'b1;
        case (funct3_i)
          F3_BEQ:           taken = breq_i;
          F3_BNE:           taken = ~breq_i;
          F3_BLT, F3_BLTU:  taken = brlt_i;
          F3_BGE, F3_BGEU:  taken = ~brlt_i;
          default:          taken = 1'b0;
        endcase
      end
      OP_JAL, OP_JALR: taken = 1'b1;
      default:         taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
// ============================================================================
// Module  : branch_redirect_ctrl
// Brief   : Resolves EX branches and sequences flush-then-redirect to fetch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int AWIDTH       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CWIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  branch_redirect_ctrl_if.slave bus,
  output logic [CWIDTH-1:0]     branch_cnt_o,
  output logic [CWIDTH-1:0]     taken_cnt_o
);

  localparam logic [CWIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CWIDTH-1:0] CNT_ONE    = CWIDTH'(1);
  localparam logic [3:0]        FLUSH_LOAD = 4'(FLUSH_CYCLES);

  redir_state_e      state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic [CWIDTH-1:0] bcnt_q, bcnt_d;
  logic [CWIDTH-1:0] tcnt_q, tcnt_d;
  logic              taken;
  logic              is_branch;
  logic [AWIDTH-1:0] tgt;

  branch_taken_dec u_dec (
    .opcode_i  (bus.opcode_i),
    .funct3_i  (bus.funct3_i),
    .breq_i    (bus.breq_i),
    .brlt_i    (bus.brlt_i),
    .taken     (taken),
    .is_branch (is_branch)
  );

  assign tgt = (bus.opcode_i == OP_JALR) ? {bus.target_i[AWIDTH-1:1], 1'b0} : bus.target_i;

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    bcnt_d     = bcnt_q;
    tcnt_d     = tcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.ex_valid_i) begin
          if (is_branch && (bcnt_q != CNT_MAX)) bcnt_d = bcnt_q + CNT_ONE;
          if (taken) begin
            // A misaligned target is reported but never redirected.
            if (tgt[1:0] != 2'b00) begin
              misalign_d = 1'b1;
            end else begin
              state_d = FLUSH;
              fcnt_d  = FLUSH_LOAD;
              pc_d    = tgt;
              if (tcnt_q != CNT_MAX) tcnt_d = tcnt_q + CNT_ONE;
            end
          end
        end
      end
      FLUSH: begin
        if (fcnt_q <= 4'd1) state_d = REDIRECT;
        else                fcnt_d  = fcnt_q - 4'd1;
      end
      REDIRECT: begin
        if (bus.redirect_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fcnt_q     <= 4'd0;
      pc_q       <= '0;
      misalign_q <= 1'b0;
      bcnt_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      bcnt_q     <= bcnt_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign bus.busy_o           = (state_q != IDLE);
  assign bus.flush_o          = (state_q == FLUSH);
  assign bus.redirect_valid_o = (state_q == REDIRECT);
  assign bus.redirect_pc_o    = pc_q;
  assign bus.misalign_o       = misalign_q;
  assign branch_cnt_o         = bcnt_q;
  assign taken_cnt_o          = tcnt_q;

endmodule

`default_nettype wire
